// File: rtl/spike_enc_pkg.sv
// Shared definitions for the rate-coding spike encoder.
// Holds the default geometry shared with the classifier top, the FSM state
// encoding (LOAD -> ARMED -> RUN) and a width helper for the idx/step counters.
package spike_enc_pkg;

    localparam int unsigned NumChannelsDef = 8;
    localparam int unsigned PixWDef        = 4;
    localparam int unsigned StepsDef       = 16;

    typedef logic [1:0] enc_state_t;

    localparam enc_state_t StLoad  = 2'd0;
    localparam enc_state_t StArmed = 2'd1;
    localparam enc_state_t StRun   = 2'd2;

    // Bits needed to index 0..n-1, never less than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rate_channel.sv
// One rate-coded channel: an intensity register and a phase accumulator.
// Ports:
//   clk_i, rst_i  clock and synchronous active-high reset
//   load_en_i     capture pix_i into the intensity register
//   pix_i         intensity to load
//   clear_i       restart the phase from zero and take the first timestep
//   adv_i         take the next timestep (acc <- acc + intensity, wrapped)
//   carry_o       spike for the timestep being taken (carry out of the add)
module rate_channel
    import spike_enc_pkg::*;
#(
    parameter int unsigned PIX_W = PixWDef
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_en_i,
    input  logic [PIX_W-1:0] pix_i,
    input  logic             clear_i,
    input  logic             adv_i,
    output logic             carry_o
);

    logic [PIX_W-1:0] int_q;
    logic [PIX_W-1:0] acc_q;
    logic [PIX_W-1:0] acc_base;
    logic [PIX_W:0]   sum;

    // A clear folds "acc <- 0" and the first timestep into one cycle, so the
    // top can register the step-0 spike together with the start.
    always_comb begin
        acc_base = clear_i ? '0 : acc_q;
        sum      = {1'b0, acc_base} + {1'b0, int_q};
    end

    assign carry_o = sum[PIX_W];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            int_q <= '0;
            acc_q <= '0;
        end else begin
            if (load_en_i) begin
                int_q <= pix_i;
            end
            if (clear_i || adv_i) begin
                acc_q <= sum[PIX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/spike_rate_encoder.sv
// Rate-coding front end: loads one intensity per channel over a valid/ready
// port, then on start emits STEPS registered spike vectors over a valid/ready
// port. Channel c spikes floor(I[c]*STEPS / 2^PIX_W) times per window.
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   pix_valid_i/pix_ready_o      pixel load handshake, pix_data_i channel 0 first
//   start_i                      begin a window (honoured only when ARMED)
//   spike_valid_o/spike_ready_i  spike vector handshake
//   spike_o, step_o              spike vector and its 0-based timestep
//   busy_o                       high while a window runs
//   done_o                       one-cycle pulse after the last beat is accepted
module spike_rate_encoder
    import spike_enc_pkg::*;
#(
    parameter int unsigned NUM_CHANNELS = NumChannelsDef,
    parameter int unsigned PIX_W        = PixWDef,
    parameter int unsigned STEPS        = StepsDef
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       pix_valid_i,
    output logic                       pix_ready_o,
    input  logic [PIX_W-1:0]           pix_data_i,
    input  logic                       start_i,
    output logic                       spike_valid_o,
    input  logic                       spike_ready_i,
    output logic [NUM_CHANNELS-1:0]    spike_o,
    output logic [$clog2(STEPS+1)-1:0] step_o,
    output logic                       busy_o,
    output logic                       done_o
);

    localparam int unsigned IdxW  = cnt_w(NUM_CHANNELS);
    localparam int unsigned StepW = cnt_w(STEPS + 1);

    enc_state_t              state_q, state_d;
    logic [IdxW-1:0]         idx_q, idx_d;
    logic [StepW-1:0]        step_q, step_d;
    logic [NUM_CHANNELS-1:0] spike_q, spike_d;
    logic                    spike_valid_q, spike_valid_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic                    pix_beat;
    logic                    spike_acc;
    logic                    last_step;
    logic                    chan_clear;
    logic                    chan_adv;
    logic [NUM_CHANNELS-1:0] carry_vec;

    assign pix_ready_o = (state_q != StRun);
    assign pix_beat    = pix_valid_i && pix_ready_o;
    assign spike_acc   = spike_valid_q && spike_ready_i;
    assign last_step   = (step_q == StepW'(STEPS - 1));

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_chan
        rate_channel #(
            .PIX_W (PIX_W)
        ) u_chan (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .load_en_i (pix_beat && (idx_q == IdxW'(g))),
            .pix_i     (pix_data_i),
            .clear_i   (chan_clear),
            .adv_i     (chan_adv),
            .carry_o   (carry_vec[g])
        );
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        step_d        = step_q;
        spike_d       = spike_q;
        spike_valid_d = spike_valid_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        chan_clear    = 1'b0;
        chan_adv      = 1'b0;

        case (state_q)
            StLoad, StArmed: begin
                // idx is 0 whenever ARMED, so a beat there restarts the load at
                // channel 0; a pixel beat also wins over a coincident start.
                if (pix_beat) begin
                    if (idx_q == IdxW'(NUM_CHANNELS - 1)) begin
                        idx_d   = '0;
                        state_d = StArmed;
                    end else begin
                        idx_d   = idx_q + IdxW'(1);
                        state_d = StLoad;
                    end
                end else if ((state_q == StArmed) && start_i) begin
                    chan_clear    = 1'b1;
                    step_d        = '0;
                    spike_d       = carry_vec;
                    spike_valid_d = 1'b1;
                    busy_d        = 1'b1;
                    state_d       = StRun;
                end
            end
            StRun: begin
                if (spike_acc) begin
                    if (last_step) begin
                        step_d        = '0;
                        spike_d       = '0;
                        spike_valid_d = 1'b0;
                        busy_d        = 1'b0;
                        done_d        = 1'b1;
                        state_d       = StArmed;
                    end else begin
                        chan_adv = 1'b1;
                        step_d   = step_q + StepW'(1);
                        spike_d  = carry_vec;
                    end
                end
            end
            default: begin
                state_d = StLoad;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= StLoad;
            idx_q         <= '0;
            step_q        <= '0;
            spike_q       <= '0;
            spike_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            step_q        <= step_d;
            spike_q       <= spike_d;
            spike_valid_q <= spike_valid_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign spike_o       = spike_q;
    assign spike_valid_o = spike_valid_q;
    assign step_o        = step_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;

endmodule

// File: tb/tb_spike_rate_encoder.sv
// Scoreboard bench for spike_rate_encoder. Expected spike vectors come from
// the closed form spike(c,k) = floor((k+1)*I/2^W) - floor(k*I/2^W).
module tb_spike_rate_encoder;

    localparam int NCH = 8;
    localparam int PW  = 4;
    localparam int ST  = 16;

    typedef int img_t[NCH];
    typedef struct {
        logic [NCH-1:0] spk;
        int             step;
        bit             last;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           pix_valid;
    logic           pix_ready;
    logic [PW-1:0]  pix_data;
    logic           start;
    logic           spike_valid;
    logic           spike_ready;
    logic [NCH-1:0] spike;
    logic [4:0]     step;
    logic           busy;
    logic           done;

    logic           u1_pix_valid;
    logic           u1_pix_ready;
    logic [PW-1:0]  u1_pix_data;
    logic           u1_start;
    logic           u1_spike_valid;
    logic [NCH-1:0] u1_spike;
    logic [0:0]     u1_step;
    logic           u1_busy;
    logic           u1_done;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t q[$];
    int   cnt[NCH];
    bit   done_pend = 1'b0;

    always #5 clk = ~clk;

    spike_rate_encoder #(
        .NUM_CHANNELS (NCH),
        .PIX_W        (PW),
        .STEPS        (ST)
    ) u_dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .pix_valid_i   (pix_valid),
        .pix_ready_o   (pix_ready),
        .pix_data_i    (pix_data),
        .start_i       (start),
        .spike_valid_o (spike_valid),
        .spike_ready_i (spike_ready),
        .spike_o       (spike),
        .step_o        (step),
        .busy_o        (busy),
        .done_o        (done)
    );

    spike_rate_encoder #(
        .NUM_CHANNELS (NCH),
        .PIX_W        (PW),
        .STEPS        (1)
    ) u_dut1 (
        .clk_i         (clk),
        .rst_i         (rst),
        .pix_valid_i   (u1_pix_valid),
        .pix_ready_o   (u1_pix_ready),
        .pix_data_i    (u1_pix_data),
        .start_i       (u1_start),
        .spike_valid_o (u1_spike_valid),
        .spike_ready_i (1'b1),
        .spike_o       (u1_spike),
        .step_o        (u1_step),
        .busy_o        (u1_busy),
        .done_o        (u1_done)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [NCH-1:0] exp_spk(input img_t img, input int k);
        logic [NCH-1:0] v;
        for (int c = 0; c < NCH; c++) begin
            v[c] = ((((k + 1) * img[c]) >> PW) - ((k * img[c]) >> PW)) != 0;
        end
        return v;
    endfunction

    // Monitor: compares every presented beat with the queue head, pops on
    // acceptance, and expects done_o exactly one cycle after the last accept.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            done_pend = 1'b0;
        end else begin
            if (done || done_pend) chk("done_pulse", int'(done), int'(done_pend));
            done_pend = 1'b0;
            if (spike_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_beat", 1, 0);
                end else begin
                    chk($sformatf("spike_step%0d", q[0].step), int'(spike), int'(q[0].spk));
                    chk("step_o", int'(step), q[0].step);
                    if (spike_ready) begin
                        for (int c = 0; c < NCH; c++) cnt[c] += int'(spike[c]);
                        if (q[0].last) done_pend = 1'b1;
                        void'(q.pop_front());
                    end
                end
            end
        end
    end

    // Drives beats for channels first..NCH-1; called at posedge+1.
    task automatic load(input img_t img, input int first);
        for (int c = first; c < NCH; c++) begin
            chk("pix_ready_load", int'(pix_ready), 1);
            pix_valid = 1'b1;
            pix_data  = PW'(img[c]);
            @(posedge clk); #1;
        end
        pix_valid = 1'b0;
    endtask

    // mode 0: ready always high, 1: pattern 1,0,0,1, 2: random ready.
    task automatic run_window(input img_t img, input int mode, input string tag);
        int base[NCH];
        int n;
        bit seen;
        exp_t e;
        for (int k = 0; k < ST; k++) begin
            e.spk  = exp_spk(img, k);
            e.step = k;
            e.last = (k == ST - 1);
            q.push_back(e);
        end
        base        = cnt;
        spike_ready = 1'b1;
        start       = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n     = 0;
        seen  = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            case (mode)
                0:       spike_ready = 1'b1;
                1:       spike_ready = ((i % 4) == 0) || ((i % 4) == 3);
                default: spike_ready = ($urandom_range(0, 2) != 0);
            endcase
            @(negedge clk);
            n++;
            if (n == 1) begin
                chk({tag, "_busy_after_start"}, int'(busy), 1);
                chk({tag, "_valid_after_start"}, int'(spike_valid), 1);
            end
            if (done) seen = 1'b1;
            @(posedge clk); #1;
        end
        chk({tag, "_done_seen"}, int'(seen), 1);
        if (mode == 0) chk({tag, "_done_latency"}, n, ST + 1);
        for (int c = 0; c < NCH; c++) begin
            chk($sformatf("%s_count_ch%0d", tag, c), cnt[c] - base[c], (img[c] * ST) >> PW);
        end
        chk({tag, "_queue_drained"}, q.size(), 0);
        chk({tag, "_busy_after_done"}, int'(busy), 0);
        spike_ready = 1'b1;
    endtask

    initial begin
        img_t img0;
        img_t img1;
        img_t imgr;
        rst          = 1'b1;
        pix_valid    = 1'b0;
        pix_data     = '0;
        start        = 1'b0;
        spike_ready  = 1'b1;
        u1_pix_valid = 1'b0;
        u1_pix_data  = '0;
        u1_start     = 1'b0;
        for (int c = 0; c < NCH; c++) cnt[c] = 0;
        img0 = '{15, 8, 4, 1, 0, 2, 12, 6};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_pix_ready", int'(pix_ready), 1);
        chk("rst_spike_valid", int'(spike_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_spike", int'(spike), 0);
        chk("rst_step", int'(step), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // start while still LOAD is ignored
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("start_in_load_busy", int'(busy), 0);

        load(img0, 0);
        run_window(img0, 0, "base");
        run_window(img0, 1, "stall");
        run_window(img0, 0, "rerun");

        // Pixel beat coinciding with start in ARMED: load restarts, no RUN.
        img1    = img0;
        img1[0] = 9;
        pix_valid = 1'b1;
        pix_data  = 4'd9;
        start     = 1'b1;
        @(posedge clk); #1;
        pix_valid = 1'b0;
        start     = 1'b0;
        @(negedge clk);
        chk("coincide_busy", int'(busy), 0);
        chk("coincide_valid", int'(spike_valid), 0);
        chk("coincide_pix_ready", int'(pix_ready), 1);
        @(posedge clk); #1;
        load(img1, 1);
        run_window(img1, 0, "coincide");

        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < NCH; c++) imgr[c] = int'($urandom_range(0, 15));
            load(imgr, 0);
            run_window(imgr, 2, "rand");
        end

        // Reset at step 5 of a window.
        load(img0, 0);
        for (int k = 0; k < ST; k++) begin
            exp_t e;
            e.spk  = exp_spk(img0, k);
            e.step = k;
            e.last = (k == ST - 1);
            q.push_back(e);
        end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(negedge clk);
        chk("pre_reset_step", int'(step), 5);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrun_rst_valid", int'(spike_valid), 0);
        chk("midrun_rst_busy", int'(busy), 0);
        chk("midrun_rst_pix_ready", int'(pix_ready), 1);
        chk("midrun_rst_done", int'(done), 0);
        @(negedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("post_rst_start_busy", int'(busy), 0);
        chk("post_rst_start_valid", int'(spike_valid), 0);
        repeat (20) @(posedge clk);
        #1;

        // STEPS=1 instance: intensity 15 never reaches the carry in one step.
        for (int c = 0; c < NCH; c++) begin
            u1_pix_valid = 1'b1;
            u1_pix_data  = 4'd15;
            @(posedge clk); #1;
        end
        u1_pix_valid = 1'b0;
        u1_start     = 1'b1;
        @(posedge clk); #1;
        u1_start = 1'b0;
        @(negedge clk);
        chk("s1_valid", int'(u1_spike_valid), 1);
        chk("s1_spike", int'(u1_spike), 0);
        chk("s1_step", int'(u1_step), 0);
        chk("s1_busy", int'(u1_busy), 1);
        chk("s1_done_early", int'(u1_done), 0);
        @(negedge clk);
        chk("s1_done", int'(u1_done), 1);
        chk("s1_valid_after", int'(u1_spike_valid), 0);
        chk("s1_pix_ready", int'(u1_pix_ready), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/spike_rate_encoder.md
# spike_rate_encoder

Rate-coding front end for the spiking classifier. It takes one pixel intensity per input channel over a valid/ready load port. It then emits a fixed-length window of binary spike vectors, one per timestep, which feed the network's 8 input lines. Spike density per channel is proportional to intensity and is deterministic. This lets a bench predict the downstream spike counts exactly.

## Interface
- NUM_CHANNELS, 8, number of input channels (spike vector width)
- PIX_W, 4, intensity width; also the phase-accumulator width
- STEPS, 16, timesteps per encoding window (≥1)
- clk_i  in  1  clock; everything is on its rising edge
- rst_i  in  1  synchronous, active-high reset
- pix_valid_i  in  1  pixel beat valid
- pix_ready_o  out  1  encoder accepts pixel beats
- pix_data_i  in  PIX_W  intensity for the next channel index (channel 0 first)
- start_i  in  1  begin a window (honoured only in ARMED)
- spike_valid_o  out  1  spike vector valid
- spike_ready_i  in  1  downstream accepts spike vector
- spike_o  out  NUM_CHANNELS  spike vector for the current timestep
- step_o  out  $clog2(STEPS+1)  index of the current timestep, 0-based
- busy_o  out  1  high in RUN
- done_o  out  1  one-cycle pulse after the last beat is accepted

## Operation
- States:
  - LOAD: pix_ready_o=1.
  - ARMED: pix_ready_o=1; all NUM_CHANNELS intensities are held.
  - RUN: pix_ready_o=0, busy_o=1.
- LOAD
  - Each accepted beat (pix_valid_i & pix_ready_o) writes intensity[idx], then idx++.
  - On the beat with idx==NUM_CHANNELS-1: idx←0, go to ARMED.
- ARMED
  - start_i=1 with no pixel beat: clear all accumulators, step←0, go to RUN.
  - An accepted pixel beat writes intensity[0], idx←1, go to LOAD. This restarts loading and overwrites.
  - If start_i and a pixel beat coincide, the pixel beat wins and start_i is ignored.
- start_i in LOAD or RUN is ignored.
- RUN
  - Per timestep and channel c: sum = acc[c] + intensity[c], computed at PIX_W+1 bits. spike_o[c] = sum[PIX_W] (the carry), acc[c] ← sum[PIX_W-1:0].
  - Accumulators and step advance only when a beat is accepted (spike_valid_o & spike_ready_i).
  - spike_o and spike_valid_o are held stable while spike_ready_i=0.
  - Over a full window, channel c emits exactly floor(intensity[c]·STEPS / 2^PIX_W) spikes. Intensity 0 never spikes.
  - The last beat (step==STEPS-1) is accepted: spike_valid_o←0, done_o pulses, go to ARMED. Intensities are retained, so start_i can rerun the same image.
- Reset:
  - state=LOAD, idx=0, all intensities=0, all accumulators=0, step=0.
  - Outputs: spike_valid_o=0, spike_o=0, done_o=0, busy_o=0, pix_ready_o=1 (asserted combinationally from state).
  - Reset in any state, including mid-RUN, abandons the window with no done_o.

## Timing
- Pixel load takes NUM_CHANNELS accepted beats. Back-to-back beats are allowed, and pix_ready_o has no bubble.
- start_i sampled at cycle t: busy_o=1 and spike_valid_o=1 at t+1, carrying step 0.
- With spike_ready_i tied high, one beat per cycle. The last beat is at t+STEPS, done_o at t+STEPS+1, and ARMED from t+STEPS+1. start_i at t+STEPS+1 begins the next window at t+STEPS+2.
- spike_o, spike_valid_o, step_o, busy_o and done_o are registered outputs.
- With backpressure, beat k is presented until accepted. Beat k+1 appears the cycle after acceptance.

## Structure
- Shared package spike_enc_pkg: the state enum (LOAD, ARMED, RUN) and a width helper for step/idx counters. Default parameter constants are shared with the classifier top.
- One sub-module, rate_channel. It holds one intensity register and one accumulator, with a load enable, a clear, an advance input and a carry output. Instantiate it NUM_CHANNELS times with a generate loop. The top holds the FSM, the idx counter and the step counter.

## Test plan
- Load 8 beats [15,8,4,1,0,2,12,6], start, spike_ready_i=1. Required per-channel spike counts over 16 steps: [15,8,4,1,0,2,12,6]. Channel 1 spikes on odd steps 1,3,…,15. done_o pulses exactly once, 17 cycles after start.
- Same image with spike_ready_i toggled 1,0,0,1,… Identical spike sequence and counts. Beats are held stable during stalls. done_o follows the 16th accepted beat.
- After done_o, assert start_i again with no reload. The spike sequence repeats bit-identically.
- In ARMED, a pixel beat arrives together with start_i. No RUN; the FSM goes to LOAD and idx=1. 7 more beats then re-arm.
- Assert rst_i at step 5 of RUN. Next cycle: spike_valid_o=0, busy_o=0, done_o never pulses, pix_ready_o=1, intensities are zero, and a start_i after reset is ignored.
- With STEPS=1, intensity 15 produces spike_o[c]=0 on the single beat (15<16), then done_o.
